// File: rtl/arquitetura_nios2_qsys_0_div_pkg.sv
// Shared types and constants for the iterative 32-bit divider.
package arquitetura_nios2_qsys_0_div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITERS = 32;
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;
  localparam logic [DIV_WIDTH-1:0] DIV_MIN_NEG   = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PREP = 2'd1,
    ST_ITER = 2'd2,
    ST_FIX  = 2'd3
  } div_state_t;

  // Two's-complement magnitude; 0x80000000 maps to itself, which is the correct unsigned magnitude.
  function automatic logic [DIV_WIDTH-1:0] magnitude(input logic [DIV_WIDTH-1:0] v);
    return v[DIV_WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/arquitetura_nios2_qsys_0_div_step.sv
// One restoring shift-subtract step: shift the next dividend bit into the
// partial remainder and subtract the divisor if it fits.
module arquitetura_nios2_qsys_0_div_step
  import arquitetura_nios2_qsys_0_div_pkg::*;
(
  input  logic [DIV_WIDTH:0]   rem_in,
  input  logic                 dvd_msb,
  input  logic [DIV_WIDTH-1:0] divisor,
  output logic [DIV_WIDTH:0]   rem_out,
  output logic                 q_bit
);

  logic [DIV_WIDTH+1:0] shifted;
  logic [DIV_WIDTH+1:0] diff;

  always_comb begin
    shifted = {rem_in, dvd_msb};
    diff    = shifted - {2'b00, divisor};
    q_bit   = ~diff[DIV_WIDTH+1];
    rem_out = q_bit ? diff[DIV_WIDTH:0] : shifted[DIV_WIDTH:0];
  end

endmodule

// File: rtl/arquitetura_nios2_qsys_0_div_cell.sv
// Fixed-latency (35-cycle) signed/unsigned 32-bit divider: operands captured
// on start, magnitudes divided by restoring iteration, signs fixed at the end.
module arquitetura_nios2_qsys_0_div_cell #(
  parameter int DIV_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [DIV_WIDTH-1:0] A_div_src1,
  input  logic [DIV_WIDTH-1:0] A_div_src2,
  input  logic                 A_div_signed,
  input  logic                 A_div_start,
  output logic                 A_div_busy,
  output logic                 A_div_done,
  output logic [DIV_WIDTH-1:0] A_div_quot,
  output logic [DIV_WIDTH-1:0] A_div_rem
);
  import arquitetura_nios2_qsys_0_div_pkg::*;

  div_state_t state_reg, state_next;

  logic [5:0]           count_reg;
  logic [DIV_WIDTH-1:0] src1_reg, src2_reg;
  logic                 signed_reg;
  logic [DIV_WIDTH-1:0] dvd_reg;
  logic [DIV_WIDTH-1:0] dvs_reg;
  logic [DIV_WIDTH:0]   prem_reg;
  logic                 q_neg_reg, r_neg_reg, dbz_reg, ovf_reg;
  logic [DIV_WIDTH-1:0] quot_reg, rem_reg;
  logic                 done_reg;

  logic [DIV_WIDTH:0]   step_rem;
  logic                 step_q;
  logic                 last_iter;

  assign last_iter = (count_reg == 6'(DIV_ITERS - 1));

  arquitetura_nios2_qsys_0_div_step u_step (
    .rem_in  (prem_reg),
    .dvd_msb (dvd_reg[DIV_WIDTH-1]),
    .divisor (dvs_reg),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (A_div_start) state_next = ST_PREP;
      ST_PREP: state_next = ST_ITER;
      ST_ITER: if (last_iter) state_next = ST_FIX;
      ST_FIX:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    A_div_busy = (state_reg != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg  <= '0;
      src1_reg   <= '0;
      src2_reg   <= '0;
      signed_reg <= 1'b0;
      dvd_reg    <= '0;
      dvs_reg    <= '0;
      prem_reg   <= '0;
      q_neg_reg  <= 1'b0;
      r_neg_reg  <= 1'b0;
      dbz_reg    <= 1'b0;
      ovf_reg    <= 1'b0;
      quot_reg   <= '0;
      rem_reg    <= '0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= (state_reg == ST_FIX);
      case (state_reg)
        ST_IDLE: begin
          if (A_div_start) begin
            src1_reg   <= A_div_src1;
            src2_reg   <= A_div_src2;
            signed_reg <= A_div_signed;
          end
        end
        ST_PREP: begin
          dvd_reg   <= signed_reg ? magnitude(src1_reg) : src1_reg;
          dvs_reg   <= signed_reg ? magnitude(src2_reg) : src2_reg;
          prem_reg  <= '0;
          count_reg <= '0;
          q_neg_reg <= signed_reg & (src1_reg[DIV_WIDTH-1] ^ src2_reg[DIV_WIDTH-1]);
          r_neg_reg <= signed_reg & src1_reg[DIV_WIDTH-1];
          dbz_reg   <= (src2_reg == '0);
          ovf_reg   <= signed_reg && (src1_reg == DIV_MIN_NEG) && (src2_reg == '1);
        end
        ST_ITER: begin
          // dvd_reg doubles as the quotient: dividend bits leave at the top, quotient bits enter at the bottom.
          prem_reg <= step_rem;
          dvd_reg  <= {dvd_reg[DIV_WIDTH-2:0], step_q};
          if (!last_iter) count_reg <= count_reg + 6'd1;
        end
        ST_FIX: begin
          if (dbz_reg) begin
            quot_reg <= DIV_ZERO_QUOT;
            rem_reg  <= src1_reg;
          end else if (ovf_reg) begin
            quot_reg <= DIV_MIN_NEG;
            rem_reg  <= '0;
          end else begin
            quot_reg <= q_neg_reg ? (~dvd_reg + 1'b1) : dvd_reg;
            rem_reg  <= r_neg_reg ? (~prem_reg[DIV_WIDTH-1:0] + 1'b1) : prem_reg[DIV_WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign A_div_done = done_reg;
  assign A_div_quot = quot_reg;
  assign A_div_rem  = rem_reg;

endmodule

// File: tb/tb_arquitetura_nios2_qsys_0_div_cell.sv
// Bench for the divider: an arithmetic reference model with a cycle-level
// timeline, checked every cycle, plus directed literal cases.
module tb_arquitetura_nios2_qsys_0_div_cell;

  logic        clk;
  logic        reset_n;
  logic [31:0] src1, src2;
  logic        sgn, start;
  logic        busy, done;
  logic [31:0] quot, rem;

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 0;

  arquitetura_nios2_qsys_0_div_cell #(.DIV_WIDTH(32)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .A_div_src1   (src1),
    .A_div_src2   (src2),
    .A_div_signed (sgn),
    .A_div_start  (start),
    .A_div_busy   (busy),
    .A_div_done   (done),
    .A_div_quot   (quot),
    .A_div_rem    (rem)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Reference arithmetic, straight from the divide rules.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    int sa, sb;
    logic [31:0] q, r;
    sa = a;
    sb = b;
    if (b == 0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (!s) begin
      q = a / b; r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 0;
    end else begin
      q = sa / sb; r = sa % sb;
    end
    return {q, r};
  endfunction

  // Timeline model: 34 busy cycles after the accepting edge, then a done cycle.
  int          remaining;
  logic        exp_done;
  logic [31:0] exp_q, exp_r;
  logic [63:0] pend;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      remaining <= 0;
      exp_done  <= 0;
      exp_q     <= 0;
      exp_r     <= 0;
      pend      <= 0;
    end else begin
      exp_done <= 0;
      if (remaining > 0) begin
        remaining <= remaining - 1;
        if (remaining == 1) begin
          exp_done <= 1;
          exp_q    <= pend[63:32];
          exp_r    <= pend[31:0];
        end
      end else if (start) begin
        remaining <= 34;
        pend      <= ref_div(src1, src2, sgn);
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("cyc_busy", {31'd0, busy}, {31'd0, remaining > 0});
      chk("cyc_done", {31'd0, done}, {31'd0, exp_done});
      chk("cyc_quot", quot, exp_q);
      chk("cyc_rem",  rem,  exp_r);
    end
  end

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s, output int lat);
    @(negedge clk);
    src1 = a; src2 = b; sgn = s; start = 1;
    @(negedge clk);
    start = 0;
    lat = 1;
    while (!done && lat < 45) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic directed(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [31:0] eq, input logic [31:0] er);
    int lat;
    do_op(a, b, s, lat);
    chk({name, "_lat"}, lat, 35);
    chk({name, "_quot"}, quot, eq);
    chk({name, "_rem"}, rem, er);
    chk({name, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic prop_check(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb, sq, sr;
    if (b == 0 || (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return;
    if (s) begin
      sa = longint'($signed(a)); sb = longint'($signed(b));
      sq = longint'($signed(quot)); sr = longint'($signed(rem));
    end else begin
      sa = longint'(a); sb = longint'(b); sq = longint'(quot); sr = longint'(rem);
    end
    chk("prop_identity", {31'd0, sa == sq * sb + sr}, 32'd1);
    chk("prop_remsize", {31'd0, (sr < 0 ? -sr : sr) < (sb < 0 ? -sb : sb)}, 32'd1);
    chk("prop_remsign", {31'd0, sr == 0 || ((sr < 0) == (sa < 0))}, 32'd1);
  endtask

  initial begin
    int lat;
    logic [31:0] a, b;
    logic s;
    logic [63:0] r;
    reset_n = 1; src1 = 0; src2 = 0; sgn = 0; start = 0;
    #3 reset_n = 0;
    #20;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_quot", quot, 32'd0);
    chk("rst_rem",  rem,  32'd0);
    checking = 1;
    @(negedge clk);
    reset_n = 1;

    directed("u100_7",   32'd100,        32'd7,          0, 32'd14,         32'd2);
    directed("s_m7_2",   32'hFFFF_FFF9,  32'd2,          1, 32'hFFFF_FFFD,  32'hFFFF_FFFF);
    directed("s_7_m2",   32'd7,          32'hFFFF_FFFE,  1, 32'hFFFF_FFFD,  32'd1);
    directed("s_div0",   32'h1234_5678,  32'd0,          1, 32'hFFFF_FFFF,  32'h1234_5678);
    directed("u_div0",   32'h1234_5678,  32'd0,          0, 32'hFFFF_FFFF,  32'h1234_5678);
    directed("s_ovf",    32'h8000_0000,  32'hFFFF_FFFF,  1, 32'h8000_0000,  32'd0);
    directed("u_min_m1", 32'h8000_0000,  32'hFFFF_FFFF,  0, 32'd0,          32'h8000_0000);
    directed("u_max_1",  32'hFFFF_FFFF,  32'd1,          0, 32'hFFFF_FFFF,  32'd0);

    // Start and operand changes while busy are ignored; a start in the done cycle is taken.
    @(negedge clk);
    src1 = 32'd100; src2 = 32'd7; sgn = 0; start = 1;
    @(negedge clk);
    start = 0;
    lat = 1;
    while (!done && lat < 80) begin
      @(negedge clk);
      lat++;
      if (lat == 5) src1 = 32'd999;
      start = (lat == 10);
    end
    chk("busy_ign_lat", lat, 35);
    chk("busy_ign_quot", quot, 32'd14);
    chk("busy_ign_rem", rem, 32'd2);
    src1 = 32'd1000; src2 = 32'd3; start = 1;
    @(negedge clk);
    start = 0;
    lat++;
    while (!done && lat < 80) begin
      @(negedge clk);
      lat++;
    end
    chk("b2b_lat", lat, 70);
    chk("b2b_quot", quot, 32'd333);
    chk("b2b_rem", rem, 32'd1);

    // Reset in flight: everything clears at once and no done follows.
    @(negedge clk);
    src1 = 32'h0000_FFFF; src2 = 32'd3; sgn = 0; start = 1;
    @(negedge clk);
    start = 0;
    repeat (19) @(negedge clk);
    #2 reset_n = 0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_quot", quot, 32'd0);
    chk("mid_rst_rem",  rem,  32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1;
    repeat (40) @(negedge clk);
    directed("after_rst", 32'h0000_FFFF, 32'd3, 0, 32'h0000_5555, 32'd0);

    for (int i = 0; i < 2000; i++) begin
      a = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: b = 32'hFFFF_FFFF;
        3: b = -$urandom_range(1, 15);
        4: b = a >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 15) == 0) a = 32'h8000_0000;
      s = $urandom_range(0, 1);
      do_op(a, b, s, lat);
      r = ref_div(a, b, s);
      chk("rnd_lat", lat, 35);
      chk("rnd_quot", quot, r[63:32]);
      chk("rnd_rem", rem, r[31:0]);
      prop_check(a, b, s);
    end

    repeat (2) @(negedge clk);
    checking = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
